// File: rtl/definitions.sv
// Shared opcode encodings for the processor's control-flow instructions.
package definitions;

  localparam logic [3:0] kJ    = 4'h1;
  localparam logic [3:0] kBRE  = 4'h2;
  localparam logic [3:0] kBRGT = 4'h3;
  localparam logic [3:0] kCALL = 4'h4;
  localparam logic [3:0] kRET  = 4'h5;

  typedef enum logic [3:0] {
    BR_J    = kJ,
    BR_BRE  = kBRE,
    BR_BRGT = kBRGT,
    BR_CALL = kCALL,
    BR_RET  = kRET
  } branch_op_t;

endpackage

// File: rtl/branch_unit_if.sv
// Bus between the fetch/ALU/loader side and the branch unit.
interface branch_unit_if #(
  parameter int IW   = 9,
  parameter int IDXW = 5,
  parameter int PCW  = 16
);
  logic [IW-1:0]   Instruction;
  logic [PCW-1:0]  PC;
  logic            Zero;
  logic            Greater;
  logic            FlagWrEn;
  logic            Stall;
  logic            LutWrEn;
  logic [IDXW-1:0] LutWrIdx;
  logic [PCW-1:0]  LutWrData;
  logic            jump_en;
  logic [PCW-1:0]  Target;
  logic            StackErr;

  modport master (
    output Instruction, PC, Zero, Greater, FlagWrEn, Stall,
           LutWrEn, LutWrIdx, LutWrData,
    input  jump_en, Target, StackErr
  );

  modport slave (
    input  Instruction, PC, Zero, Greater, FlagWrEn, Stall,
           LutWrEn, LutWrIdx, LutWrData,
    output jump_en, Target, StackErr
  );
endinterface

// File: rtl/ret_stack.sv
// Return-address LIFO; pushes when full and pops when empty are dropped
// and reported on ovf/unf for the cycle they are requested.
module ret_stack #(
  parameter int PCW = 16,
  parameter int RSD = 4
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           push,
  input  logic           pop,
  input  logic [PCW-1:0] din,
  output logic [PCW-1:0] top,
  output logic           empty,
  output logic           full,
  output logic           ovf,
  output logic           unf
);
  localparam int SPW = $clog2(RSD + 1);
  // Storage is padded to a power of two so pointers index it at full width.
  localparam int DEPTH = 1 << SPW;
  localparam logic [SPW-1:0] SP_FULL = SPW'(RSD);

  logic [SPW-1:0] sp;
  logic [PCW-1:0] mem [DEPTH];

  assign empty = (sp == '0);
  assign full  = (sp == SP_FULL);
  assign ovf   = push && full;
  assign unf   = pop && empty;
  assign top   = empty ? '0 : mem[sp - SPW'(1)];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[sp] <= din;
      sp      <= sp + SPW'(1);
    end else if (pop && !empty) begin
      sp <= sp - SPW'(1);
    end
  end
endmodule

// File: rtl/branch_unit.sv
// Branch/jump controller: registered ALU flags, writable target LUT and a
// return stack for CALL/RET. Redirect decode is combinational.
module branch_unit
  import definitions::*;
#(
  parameter int IW   = 9,
  parameter int OPW  = 4,
  parameter int IDXW = 5,
  parameter int PCW  = 16,
  parameter int RSD  = 4
) (
  input logic          Clk,
  input logic          Reset_n,
  branch_unit_if.slave bus
);
  logic [OPW-1:0]  op;
  logic [IDXW-1:0] idx;
  logic [PCW-1:0]  lut [2**IDXW];
  logic [PCW-1:0]  lut_rd;
  logic [PCW-1:0]  stk_top;
  logic [PCW-1:0]  target;
  logic            jump;
  logic            zero_q;
  logic            greater_q;
  logic            stack_err;
  logic            push;
  logic            pop;
  logic            stk_empty;
  logic            stk_full;
  logic            ovf;
  logic            unf;

  assign op     = bus.Instruction[IW-1 -: OPW];
  assign idx    = bus.Instruction[IDXW-1:0];
  assign lut_rd = lut[idx];
  assign push   = (op == kCALL) && !bus.Stall;
  assign pop    = (op == kRET) && !bus.Stall;

  ret_stack #(.PCW(PCW), .RSD(RSD)) u_ret_stack (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .push   (push),
    .pop    (pop),
    .din    (bus.PC + PCW'(1)),
    .top    (stk_top),
    .empty  (stk_empty),
    .full   (stk_full),
    .ovf    (ovf),
    .unf    (unf)
  );

  always_comb begin
    jump   = 1'b0;
    target = '0;
    case (op)
      kJ, kCALL: begin
        jump   = 1'b1;
        target = lut_rd;
      end
      kBRE: if (zero_q) begin
        jump   = 1'b1;
        target = lut_rd;
      end
      kBRGT: if (greater_q) begin
        jump   = 1'b1;
        target = lut_rd;
      end
      kRET: if (!stk_empty) begin
        jump   = 1'b1;
        target = stk_top;
      end
      default: ;
    endcase
  end

  assign bus.jump_en  = jump;
  assign bus.Target   = target;
  assign bus.StackErr = stack_err;

  // LUT reads above see the pre-edge contents, so a same-cycle write is not forwarded.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      zero_q    <= 1'b0;
      greater_q <= 1'b0;
      stack_err <= 1'b0;
      for (int i = 0; i < 2**IDXW; i++) lut[i] <= '0;
    end else begin
      if (bus.FlagWrEn && !bus.Stall) begin
        zero_q    <= bus.Zero;
        greater_q <= bus.Greater;
      end
      if (ovf || unf) stack_err <= 1'b1;
      if (bus.LutWrEn) lut[bus.LutWrIdx] <= bus.LutWrData;
    end
  end

  stack_state_sane: assert property (@(posedge Clk) disable iff (!Reset_n)
    stk_full |-> !stk_empty);
endmodule

// File: tb/tb_branch_unit.sv
// Directed vectors drive the branch unit; a negedge monitor pops the
// expected-response queue and compares against the DUT outputs.
module tb_branch_unit;
  import definitions::*;

  localparam logic [3:0] NOP = 4'h0;

  logic Clk = 1'b0;
  logic Reset_n;
  always #5 Clk = ~Clk;

  branch_unit_if #(.IW(9), .IDXW(5), .PCW(16)) bus ();

  branch_unit #(.IW(9), .OPW(4), .IDXW(5), .PCW(16), .RSD(4)) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  typedef struct {
    logic        rst_n;
    logic [3:0]  op;
    logic [4:0]  idx;
    logic [15:0] pc;
    logic        z;
    logic        g;
    logic        fwe;
    logic        stall;
    logic        lwe;
    logic [4:0]  lidx;
    logic [15:0] ldata;
    logic        ej;
    logic [15:0] et;
    logic        ee;
  } vec_t;

  typedef struct packed {
    logic [7:0]  id;
    logic        j;
    logic [15:0] t;
    logic        e;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  logic chk_live = 1'b0;

  task automatic add(input logic rst_n, input logic [3:0] op, input logic [4:0] idx,
                     input logic [15:0] pc, input logic z, input logic g, input logic fwe,
                     input logic stall, input logic lwe, input logic [4:0] lidx,
                     input logic [15:0] ldata, input logic ej, input logic [15:0] et,
                     input logic ee);
    vec_t v;
    v.rst_n = rst_n; v.op = op; v.idx = idx; v.pc = pc;
    v.z = z; v.g = g; v.fwe = fwe; v.stall = stall;
    v.lwe = lwe; v.lidx = lidx; v.ldata = ldata;
    v.ej = ej; v.et = et; v.ee = ee;
    vecs.push_back(v);
  endtask

  task automatic v(input logic [3:0] op, input logic [4:0] idx, input logic [15:0] pc,
                   input logic ej, input logic [15:0] et, input logic ee);
    add(1'b1, op, idx, pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0, ej, et, ee);
  endtask

  task automatic vs(input logic [3:0] op, input logic [4:0] idx, input logic [15:0] pc,
                    input logic ej, input logic [15:0] et, input logic ee);
    add(1'b1, op, idx, pc, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 16'h0, ej, et, ee);
  endtask

  task automatic vf(input logic [3:0] op, input logic [4:0] idx, input logic z, input logic g,
                    input logic stall, input logic ej, input logic [15:0] et, input logic ee);
    add(1'b1, op, idx, 16'h0, z, g, 1'b1, stall, 1'b0, 5'd0, 16'h0, ej, et, ee);
  endtask

  task automatic vl(input logic [3:0] op, input logic [4:0] idx, input logic [4:0] lidx,
                    input logic [15:0] ldata, input logic ej, input logic [15:0] et,
                    input logic ee);
    add(1'b1, op, idx, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, lidx, ldata, ej, et, ee);
  endtask

  task automatic vr(input logic [3:0] op, input logic [4:0] idx,
                    input logic ej, input logic [15:0] et, input logic ee);
    add(1'b0, op, idx, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0, ej, et, ee);
  endtask

  task automatic build();
    // reset state, LUT load, collision
    vr(kJ,   5'd0, 1'b1, 16'h0000, 1'b0);
    vl(NOP,  5'd0, 5'd3, 16'h01FF, 1'b0, 16'h0000, 1'b0);
    v (kJ,   5'd3, 16'h0, 1'b1, 16'h01FF, 1'b0);
    v (kJ,   5'd5, 16'h0, 1'b1, 16'h0000, 1'b0);
    vl(kJ,   5'd3, 5'd3, 16'h0ABC, 1'b1, 16'h01FF, 1'b0);
    v (kJ,   5'd3, 16'h0, 1'b1, 16'h0ABC, 1'b0);
    vl(NOP,  5'd0, 5'd3, 16'h01FF, 1'b0, 16'h0000, 1'b0);
    // registered flags
    vf(NOP,  5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    v (kBRE, 5'd3, 16'h0, 1'b1, 16'h01FF, 1'b0);
    v (kBRGT,5'd3, 16'h0, 1'b0, 16'h0000, 1'b0);
    vf(kBRE, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 16'h01FF, 1'b0);
    v (kBRE, 5'd3, 16'h0, 1'b0, 16'h0000, 1'b0);
    vf(NOP,  5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    v (kBRGT,5'd3, 16'h0, 1'b1, 16'h01FF, 1'b0);
    vf(NOP,  5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    v (kBRGT,5'd3, 16'h0, 1'b1, 16'h01FF, 1'b0);
    v (kBRE, 5'd3, 16'h0, 1'b0, 16'h0000, 1'b0);
    // nested call/return, back-to-back
    v (kCALL,5'd3, 16'h0010, 1'b1, 16'h01FF, 1'b0);
    v (kCALL,5'd3, 16'h0020, 1'b1, 16'h01FF, 1'b0);
    v (kRET, 5'd0, 16'h0, 1'b1, 16'h0021, 1'b0);
    v (kRET, 5'd0, 16'h0, 1'b1, 16'h0011, 1'b0);
    v (NOP,  5'd0, 16'h0, 1'b0, 16'h0000, 1'b0);
    // overflow
    v (kCALL,5'd3, 16'h0100, 1'b1, 16'h01FF, 1'b0);
    v (kCALL,5'd3, 16'h0200, 1'b1, 16'h01FF, 1'b0);
    v (kCALL,5'd3, 16'h0300, 1'b1, 16'h01FF, 1'b0);
    v (kCALL,5'd3, 16'h0400, 1'b1, 16'h01FF, 1'b0);
    v (kCALL,5'd3, 16'h0500, 1'b1, 16'h01FF, 1'b0);
    v (kRET, 5'd0, 16'h0, 1'b1, 16'h0401, 1'b1);
    v (kRET, 5'd0, 16'h0, 1'b1, 16'h0301, 1'b1);
    v (kRET, 5'd0, 16'h0, 1'b1, 16'h0201, 1'b1);
    v (kRET, 5'd0, 16'h0, 1'b1, 16'h0101, 1'b1);
    // reset between edges
    v (kCALL,5'd3, 16'h0A00, 1'b1, 16'h01FF, 1'b1);
    v (kCALL,5'd3, 16'h0B00, 1'b1, 16'h01FF, 1'b1);
    vr(kJ,   5'd3, 1'b1, 16'h0000, 1'b0);
    vr(kRET, 5'd0, 1'b0, 16'h0000, 1'b0);
    // stall, underflow
    vs(kRET, 5'd0, 16'h0, 1'b0, 16'h0000, 1'b0);
    v (NOP,  5'd0, 16'h0, 1'b0, 16'h0000, 1'b0);
    vs(kCALL,5'd3, 16'h0050, 1'b1, 16'h0000, 1'b0);
    v (kRET, 5'd0, 16'h0, 1'b0, 16'h0000, 1'b0);
    v (NOP,  5'd0, 16'h0, 1'b0, 16'h0000, 1'b1);
    // PC wrap and stalled pop
    v (kCALL,5'd3, 16'hFFFF, 1'b1, 16'h0000, 1'b1);
    v (kRET, 5'd0, 16'h0, 1'b1, 16'h0000, 1'b1);
    v (kRET, 5'd0, 16'h0, 1'b0, 16'h0000, 1'b1);
    v (kCALL,5'd3, 16'h0030, 1'b1, 16'h0000, 1'b1);
    vs(kRET, 5'd0, 16'h0, 1'b1, 16'h0031, 1'b1);
    v (kRET, 5'd0, 16'h0, 1'b1, 16'h0031, 1'b1);
    v (kRET, 5'd0, 16'h0, 1'b0, 16'h0000, 1'b1);
  endtask

  always @(negedge Clk) begin : monitor
    exp_t e;
    if (chk_live) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard: output presented with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        tests += 3;
        if (bus.jump_en !== e.j) begin
          fails++;
          $display("FAIL vec%0d jump_en: got %0b, want %0b", e.id, bus.jump_en, e.j);
        end
        if (bus.Target !== e.t) begin
          fails++;
          $display("FAIL vec%0d Target: got %h, want %h", e.id, bus.Target, e.t);
        end
        if (bus.StackErr !== e.e) begin
          fails++;
          $display("FAIL vec%0d StackErr: got %0b, want %0b", e.id, bus.StackErr, e.e);
        end
      end
    end
  end

  initial begin : stimulus
    vec_t cur;
    Reset_n         = 1'b0;
    bus.Instruction = '0;
    bus.PC          = '0;
    bus.Zero        = 1'b0;
    bus.Greater     = 1'b0;
    bus.FlagWrEn    = 1'b0;
    bus.Stall       = 1'b0;
    bus.LutWrEn     = 1'b0;
    bus.LutWrIdx    = '0;
    bus.LutWrData   = '0;
    build();
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge Clk);
      #1;
      cur             = vecs[i];
      Reset_n         = cur.rst_n;
      bus.Instruction = {cur.op, cur.idx};
      bus.PC          = cur.pc;
      bus.Zero        = cur.z;
      bus.Greater     = cur.g;
      bus.FlagWrEn    = cur.fwe;
      bus.Stall       = cur.stall;
      bus.LutWrEn     = cur.lwe;
      bus.LutWrIdx    = cur.lidx;
      bus.LutWrData   = cur.ldata;
      exp_q.push_back('{id: 8'(i), j: cur.ej, t: cur.et, e: cur.ee});
      chk_live = 1'b1;
    end
    @(posedge Clk);
    #1;
    chk_live = 1'b0;
    bus.Instruction = '0;
    bus.LutWrEn     = 1'b0;
    @(negedge Clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/branch_unit.md
# branch_unit

Parametrised branch/jump controller for the basic processor, replacing the combinational jump decoder between instruction ROM, ALU flags and the program counter. It keeps a registered flag pair, a run-time writable jump-target lookup table and a return-address stack, so the ISA gains `CALL`/`RET`. Target tables are loaded by the program loader instead of being hard-coded.

## Interface
- `IW`, 9: instruction width. Opcode is `Instruction[IW-1:IW-OPW]`; index is `Instruction[IDXW-1:0]`.
- `OPW`, 4: opcode width.
- `IDXW`, 5: LUT index width; LUT depth is 2^IDXW.
- `PCW`, 16: program counter and target width.
- `RSD`, 4: return-stack depth; must be ≥1.

Ports:
- `Clk`, in, 1: clock. All state updates on the rising edge.
- `Reset_n`, in, 1: asynchronous, active-low reset.
- `Instruction`, in, IW: current instruction.
- `PC`, in, PCW: address of the current instruction.
- `Zero`, in, 1: ALU result equals 0.
- `Greater`, in, 1: ALU greater-than flag.
- `FlagWrEn`, in, 1: capture `Zero`/`Greater` this cycle.
- `Stall`, in, 1: freezes flag and stack updates.
- `LutWrEn`, in, 1: write the target LUT.
- `LutWrIdx`, in, IDXW: LUT write address.
- `LutWrData`, in, PCW: LUT write data.
- `jump_en`, out, 1: redirect the PC this cycle.
- `Target`, out, PCW: redirect address. It is 0 whenever `jump_en` = 0.
- `StackErr`, out, 1: sticky flag for stack overflow or underflow.

## Operation
- **Registered flags.** `ZeroQ`/`GreaterQ` load `Zero`/`Greater` when `FlagWrEn && !Stall`. Branches test only the registered copies.
- **Decode** (combinational, from `Instruction` and current state):
  - `kJ`: `jump_en` = 1; `Target` = `LUT[idx]`.
  - `kBRE`: `jump_en` = `ZeroQ`; `Target` = `LUT[idx]`.
  - `kBRGT`: `jump_en` = `GreaterQ`; `Target` = `LUT[idx]`.
  - `kCALL`: `jump_en` = 1; `Target` = `LUT[idx]`. At the edge, push `PC+1`, computed modulo 2^PCW (`PC` = all-ones pushes 0).
  - `kRET`: if the stack is non-empty, `jump_en` = 1 and `Target` = top of stack; the stack pops at the edge.
  - Any other opcode: `jump_en` = 0, `Target` = 0.
- **Return stack.**
  - Stack pointer `Sp` ranges 0..RSD.
  - Empty when `Sp` = 0; full when `Sp` = RSD.
  - Push and pop occur only when `!Stall`.
- **Stack overflow** (`kCALL` while full): the jump is still taken, the push is dropped, `Sp` is unchanged, and `StackErr` is set.
- **Stack underflow** (`kRET` while empty): `jump_en` = 0, `Target` = 0, `Sp` stays 0, and `StackErr` is set.
- **`StackErr`** is cleared only by reset.
- **Stall behaviour.**
  - Outputs still decode normally.
  - Flag capture, push, pop and `StackErr` setting are all suppressed.
  - LUT writes ignore `Stall`.
- **LUT write/read collision.** A write and a read of the same index in the same cycle return the old value. The new value is visible from the next cycle.
- **Simultaneous flag update and branch.** When `FlagWrEn` and a branch occur in the same cycle, the branch uses the pre-edge flags.
- **Reset values.** All LUT entries = 0, `ZeroQ` = `GreaterQ` = 0, `Sp` = 0, stack contents = 0, `StackErr` = 0. Consequently `jump_en` = 1 with `Target` = 0 for `kJ` after reset.
- **Reset mid-operation.** Asserting reset at any time returns all state to these values immediately, without waiting for a clock edge.

## Timing
- `jump_en`/`Target` are combinational from `Instruction` and registered state: zero cycles of latency, valid in the same cycle.
- State written at edge N (flags, LUT, stack) affects decode from cycle N+1.
- Back-to-back `kCALL`/`kRET` are supported every cycle; a `kRET` directly after a `kCALL` returns the just-pushed `PC+1`.
- There is no handshake; the PC consumes `jump_en`/`Target` in the same cycle.

## Structure
- Add the opcode constants `kCALL` and `kRET` to the `definitions` package, alongside `kJ`, `kBRE` and `kBRGT`. Their encodings are assigned there.
- Also add a `branch_op_t` enum covering the five control opcodes to `definitions`.
- Implement the LIFO as one sub-module, `ret_stack`, parametrised by `PCW` and `RSD`.
  - Ports: `push`, `pop`, `din`, `top`, `empty`, `full`, `ovf`, `unf`.
  - `Clk`/`Reset_n` are shared with `branch_unit`.
- The LUT and flag registers live in `branch_unit`.

## Test plan
- **LUT load and jump.** Reset, then write `LUT[3]` = 16'h01FF. Issue `kJ` idx 3 → `jump_en` = 1, `Target` = 16'h01FF. Issue `kJ` idx 5 → `Target` = 0.
- **Conditional branches on registered flags.** Pulse `FlagWrEn` with `Zero`=1, `Greater`=0. Next cycle, `kBRE` idx 3 → taken, 16'h01FF; `kBRGT` → not taken, `Target` = 0. In a cycle with `FlagWrEn` and `Zero`=0 together with `kBRE`, the branch is still taken; the following `kBRE` is not taken.
- **Nested calls and returns.** `kCALL` idx 3 at PC=16'h0010, then `kCALL` idx 3 at PC=16'h0020. Then `kRET` → `Target` = 16'h0021; next `kRET` → 16'h0011. `StackErr` stays 0.
- **Stack overflow.** With RSD=4, issue 5 `kCALL`s. The 5th still jumps and `StackErr` = 1. Four `kRET`s then return the first four addresses in LIFO order.
- **Stack underflow and stall.** Issue `kRET` on an empty stack → `jump_en` = 0 and `StackErr` = 1. Issue `kCALL` with `Stall`=1 → jump taken, `Sp` unchanged, and a subsequent `kRET` underflows.
- **Reset mid-operation and PC wrap.** Push two entries, then assert `Reset_n`=0 between clock edges → all state returns to reset values immediately, the LUT reads 0 and `StackErr` = 0. Separately, `kCALL` at PC=16'hFFFF followed by `kRET` gives `Target` = 16'h0000.
